// File: rtl/vblank_arbiter.sv
// vblank_arbiter: serialises game-state update grants inside each vertical blank window, round-robin across frames.
// Define STARSOC_VBLANK_TIMEOUT_EN to compile in the per-grant slot timer, MAX_SLOT enforcement and timeout_flag.
module vblank_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_SLOT = 256
) (
  input  logic               pixel_clk,
  input  logic               reset_n,
  input  logic               vblank,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  input  logic               clr_flags,
  output logic [NUM_REQ-1:0] gnt,
  output logic               window_open,
  output logic [15:0]        frame_count,
  output logic               overrun,
  output logic [NUM_REQ-1:0] timeout_flag
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ARB, GRANT} state_e;

  state_e             state_q, state_d;
  logic               vblank_q;
  logic               vbRise, vbFall;
  logic [PTR_W-1:0]   rrPtr_q, rrPtr_d;
  logic [PTR_W-1:0]   grantIdx_q, grantIdx_d;
  logic [PTR_W-1:0]   hitIdx, candIdx, nextPtr;
  logic               hit;
  logic [NUM_REQ-1:0] served_q, served_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [15:0]        frameCount_q, frameCount_d;
  logic               overrun_q, overrun_d;
  logic               slotExpired;
  logic               grantEnd;

  assign vbRise   = vblank & ~vblank_q;
  assign vbFall   = ~vblank & vblank_q;
  assign grantEnd = done[grantIdx_q] | slotExpired;
  assign nextPtr  = (grantIdx_q == PTR_W'(NUM_REQ - 1)) ? '0 : grantIdx_q + PTR_W'(1);

  // Scan downward so the last hit written is the one closest to rrPtr_q.
  always_comb begin
    hit     = 1'b0;
    hitIdx  = '0;
    candIdx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      candIdx = PTR_W'((int'(rrPtr_q) + k) % NUM_REQ);
      if (req[candIdx] && !served_q[candIdx]) begin
        hit    = 1'b1;
        hitIdx = candIdx;
      end
    end
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (vbRise) state_d = ARB;
      ARB: begin
        if (!vblank)  state_d = IDLE;
        else if (hit) state_d = GRANT;
      end
      GRANT: begin
        if (vbFall)        state_d = IDLE;
        else if (grantEnd) state_d = ARB;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d        = gnt_q;
    served_d     = served_q;
    rrPtr_d      = rrPtr_q;
    grantIdx_d   = grantIdx_q;
    frameCount_d = frameCount_q;
    overrun_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (vbRise) begin
          frameCount_d = frameCount_q + 16'd1;
          served_d     = '0;
        end
      end
      ARB: begin
        if (vblank && hit) begin
          gnt_d         = '0;
          gnt_d[hitIdx] = 1'b1;
          grantIdx_d    = hitIdx;
        end
      end
      GRANT: begin
        if (vbFall || grantEnd) begin
          gnt_d                = '0;
          served_d[grantIdx_q] = 1'b1;
          rrPtr_d              = nextPtr;
          overrun_d            = vbFall;
        end
      end
      default: ;
    endcase
  end

  // vblank_q comes out of reset high so a vblank already active at release is not taken as a rising edge.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      vblank_q     <= 1'b1;
      gnt_q        <= '0;
      served_q     <= '0;
      rrPtr_q      <= '0;
      grantIdx_q   <= '0;
      frameCount_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      vblank_q     <= vblank;
      gnt_q        <= gnt_d;
      served_q     <= served_d;
      rrPtr_q      <= rrPtr_d;
      grantIdx_q   <= grantIdx_d;
      frameCount_q <= frameCount_d;
      overrun_q    <= overrun_d;
    end
  end

  assign gnt         = gnt_q;
  assign window_open = (state_q != IDLE);
  assign frame_count = frameCount_q;
  assign overrun     = overrun_q;

`ifdef STARSOC_VBLANK_TIMEOUT_EN
  localparam int TMR_W = $clog2(MAX_SLOT);

  logic [TMR_W-1:0]   slotTimer_q;
  logic [NUM_REQ-1:0] timeoutFlag_q, timeoutFlag_d, timeoutSet;

  assign slotExpired = (state_q == GRANT) && (slotTimer_q == TMR_W'(MAX_SLOT - 1));

  // A timeout only counts when neither the window end nor done claims the same cycle.
  always_comb begin
    timeoutSet = '0;
    if (slotExpired && !vbFall && !done[grantIdx_q]) begin
      timeoutSet[grantIdx_q] = 1'b1;
    end
    timeoutFlag_d = clr_flags ? timeoutSet : (timeoutFlag_q | timeoutSet);
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      slotTimer_q   <= '0;
      timeoutFlag_q <= '0;
    end else begin
      timeoutFlag_q <= timeoutFlag_d;
      if (state_q != GRANT) begin
        slotTimer_q <= '0;
      end else if (slotTimer_q != '1) begin
        slotTimer_q <= slotTimer_q + TMR_W'(1);
      end
    end
  end

  assign timeout_flag = timeoutFlag_q;
`else
  logic unusedCfg;

  assign unusedCfg    = clr_flags | (MAX_SLOT < 2);
  assign slotExpired  = 1'b0;
  assign timeout_flag = '0;
`endif

endmodule

// File: tb/tb_vblank_arbiter.sv
// tb_vblank_arbiter: directed scenarios with hand-computed expectations for vblank_arbiter (NUM_REQ=4, MAX_SLOT=8).
// Both the default build and the STARSOC_VBLANK_TIMEOUT_EN build are covered by the timeout scenario.
module tb_vblank_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int MAX_SLOT = 8;

  logic               pixel_clk = 1'b0;
  logic               reset_n   = 1'b0;
  logic               vblank    = 1'b0;
  logic [NUM_REQ-1:0] req       = '0;
  logic [NUM_REQ-1:0] done      = '0;
  logic               clr_flags = 1'b0;
  logic [NUM_REQ-1:0] gnt;
  logic               window_open;
  logic [15:0]        frame_count;
  logic               overrun;
  logic [NUM_REQ-1:0] timeout_flag;

  int errors = 0;
  int checks = 0;

  vblank_arbiter #(.NUM_REQ(NUM_REQ), .MAX_SLOT(MAX_SLOT)) dut (
    .pixel_clk   (pixel_clk),
    .reset_n     (reset_n),
    .vblank      (vblank),
    .req         (req),
    .done        (done),
    .clr_flags   (clr_flags),
    .gnt         (gnt),
    .window_open (window_open),
    .frame_count (frame_count),
    .overrun     (overrun),
    .timeout_flag(timeout_flag)
  );

  always #5 pixel_clk = ~pixel_clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Inputs change and outputs are observed on the falling edge, away from the active edge.
  task automatic cyc();
    @(posedge pixel_clk);
    @(negedge pixel_clk);
  endtask

  task automatic doReset();
    reset_n   = 1'b0;
    vblank    = 1'b0;
    req       = '0;
    done      = '0;
    clr_flags = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge pixel_clk);
    @(negedge pixel_clk);
    checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL reset_gnt: got %b expected 0000", gnt); end
    checks++; if (window_open !== 1'b0) begin errors++; $display("[TB] FAIL reset_window: got %b expected 0", window_open); end
    checks++; if (frame_count !== 16'h0000) begin errors++; $display("[TB] FAIL reset_frame: got %h expected 0000", frame_count); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); end
    checks++; if (timeout_flag !== 4'b0000) begin errors++; $display("[TB] FAIL reset_tflag: got %b expected 0000", timeout_flag); end
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_round_robin();
    logic [3:0] expG;
    doReset();
    req    = 4'b1111;
    vblank = 1'b1;
    cyc();
    checks++; if (window_open !== 1'b1) begin errors++; $display("[TB] FAIL rr_window_open: got %b expected 1", window_open); end
    checks++; if (frame_count !== 16'd1) begin errors++; $display("[TB] FAIL rr_frame1: got %0d expected 1", frame_count); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL rr_arb_cycle: got %b expected 0000", gnt); end
    cyc();
    for (int r = 0; r < 4; r++) begin
      expG = 4'(1 << r);
      for (int c = 0; c < 4; c++) begin
        checks++; if (gnt !== expG) begin errors++; $display("[TB] FAIL rr_gnt r=%0d c=%0d: got %b expected %b", r, c, gnt, expG); end
        if (c == 3) done = expG;
        cyc();
      end
      done = '0;
      checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL rr_gap r=%0d: got %b expected 0000", r, gnt); end
      cyc();
    end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL rr_all_served: got %b expected 0000", gnt); end
    vblank = 1'b0;
    cyc();
    checks++; if (window_open !== 1'b0) begin errors++; $display("[TB] FAIL rr_window_close: got %b expected 0", window_open); end
    // Window 2 starts from requester 0 again; windows 3 and 4 serve one request each.
    vblank = 1'b1;
    cyc();
    cyc();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("[TB] FAIL rr_win2_first: got %b expected 0001", gnt); end
    done = 4'b0001; req = '0;
    cyc();
    done = '0; vblank = 1'b0;
    cyc();
    req = 4'b0110; vblank = 1'b1;
    cyc();
    cyc();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("[TB] FAIL rr_win3_first: got %b expected 0010", gnt); end
    done = 4'b0010; req = '0;
    cyc();
    done = '0; vblank = 1'b0;
    cyc();
    req = 4'b0110; vblank = 1'b1;
    cyc();
    cyc();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("[TB] FAIL rr_win4_first: got %b expected 0100", gnt); end
    done = 4'b0100; req = '0;
    cyc();
    done = '0; vblank = 1'b0;
    cyc();
    checks++; if (frame_count !== 16'd4) begin errors++; $display("[TB] FAIL rr_frame4: got %0d expected 4", frame_count); end
  endtask

  task automatic test_once_per_window();
    int cnt;
    doReset();
    req  = 4'b0100;
    done = 4'b0100;
    for (int w = 1; w <= 3; w++) begin
      vblank = 1'b1;
      cyc();
      checks++; if (frame_count !== 16'(w)) begin errors++; $display("[TB] FAIL once_frame w=%0d: got %0d expected %0d", w, frame_count, w); end
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
        if (gnt == 4'b0100) cnt++;
        cyc();
      end
      checks++; if (cnt !== 1) begin errors++; $display("[TB] FAIL once_count w=%0d: got %0d expected 1", w, cnt); end
      vblank = 1'b0;
      cyc();
      cyc();
    end
    req  = '0;
    done = '0;
  endtask

  task automatic test_timeout();
    int cnt;
    doReset();
    req    = 4'b0010;
    vblank = 1'b1;
    cyc();
    cyc();
    checks++; if (timeout_flag !== 4'b0000) begin errors++; $display("[TB] FAIL tmo_flag_early: got %b expected 0000", timeout_flag); end
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (gnt == 4'b0010) cnt++;
      cyc();
    end
`ifdef STARSOC_VBLANK_TIMEOUT_EN
    checks++; if (cnt !== MAX_SLOT) begin errors++; $display("[TB] FAIL tmo_len: got %0d expected %0d", cnt, MAX_SLOT); end
    checks++; if (timeout_flag !== 4'b0010) begin errors++; $display("[TB] FAIL tmo_flag_set: got %b expected 0010", timeout_flag); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL tmo_no_regrant: got %b expected 0000", gnt); end
    clr_flags = 1'b1;
    cyc();
    clr_flags = 1'b0;
    checks++; if (timeout_flag !== 4'b0000) begin errors++; $display("[TB] FAIL tmo_flag_clr: got %b expected 0000", timeout_flag); end
    vblank = 1'b0;
    cyc();
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL tmo_no_overrun: got %b expected 0", overrun); end
`else
    checks++; if (cnt !== 20) begin errors++; $display("[TB] FAIL hold_len: got %0d expected 20", cnt); end
    checks++; if (timeout_flag !== 4'b0000) begin errors++; $display("[TB] FAIL hold_tflag: got %b expected 0000", timeout_flag); end
    vblank = 1'b0;
    cyc();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL hold_release: got %b expected 0000", gnt); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL hold_overrun: got %b expected 1", overrun); end
    clr_flags = 1'b1;
    cyc();
    clr_flags = 1'b0;
    checks++; if (timeout_flag !== 4'b0000) begin errors++; $display("[TB] FAIL hold_tflag_clr: got %b expected 0000", timeout_flag); end
`endif
    req = '0;
    cyc();
  endtask

  task automatic test_overrun();
    doReset();
    vblank = 1'b1;
    cyc();
    req = 4'b0001;
    cyc();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("[TB] FAIL ovr_gnt: got %b expected 0001", gnt); end
    cyc();
    cyc();
    cyc();
    checks++; if (gnt !== 4'b0001 || overrun !== 1'b0) begin errors++; $display("[TB] FAIL ovr_before: got gnt=%b ovr=%b expected gnt=0001 ovr=0", gnt, overrun); end
    vblank = 1'b0;
    cyc();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL ovr_gnt_drop: got %b expected 0000", gnt); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_pulse: got %b expected 1", overrun); end
    checks++; if (window_open !== 1'b0) begin errors++; $display("[TB] FAIL ovr_window: got %b expected 0", window_open); end
    cyc();
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL ovr_one_cycle: got %b expected 0", overrun); end
    // The cut-off grant still advanced the pointer, so requester 1 is served first next window.
    req    = 4'b0011;
    vblank = 1'b1;
    cyc();
    cyc();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("[TB] FAIL ovr_next_first: got %b expected 0010", gnt); end
    done = 4'b0010;
    cyc();
    done = '0;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL ovr_next_gap: got %b expected 0000", gnt); end
    cyc();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("[TB] FAIL ovr_next_second: got %b expected 0001", gnt); end
    done = 4'b0001; req = '0;
    cyc();
    done = '0; vblank = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid_grant();
    doReset();
    req    = 4'b0001;
    vblank = 1'b1;
    cyc();
    cyc();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("[TB] FAIL mid_gnt: got %b expected 0001", gnt); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL mid_async_gnt: got %b expected 0000", gnt); end
    checks++; if (window_open !== 1'b0 || overrun !== 1'b0) begin errors++; $display("[TB] FAIL mid_async_ctl: got win=%b ovr=%b expected 0 0", window_open, overrun); end
    checks++; if (frame_count !== 16'd0 || timeout_flag !== 4'b0000) begin errors++; $display("[TB] FAIL mid_async_cnt: got fc=%0d tf=%b expected 0 0000", frame_count, timeout_flag); end
    @(negedge pixel_clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (gnt !== 4'b0000 || window_open !== 1'b0) begin errors++; $display("[TB] FAIL mid_no_window i=%0d: got gnt=%b win=%b expected 0000 0", i, gnt, window_open); end
    end
    vblank = 1'b0;
    cyc();
    vblank = 1'b1;
    cyc();
    checks++; if (window_open !== 1'b1 || frame_count !== 16'd1) begin errors++; $display("[TB] FAIL mid_reopen: got win=%b fc=%0d expected 1 1", window_open, frame_count); end
    cyc();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("[TB] FAIL mid_regrant: got %b expected 0001", gnt); end
    done = 4'b0001; req = '0;
    cyc();
    done = '0; vblank = 1'b0;
    cyc();
  endtask

  task automatic test_wrap();
    doReset();
    // Preload the counter near its top instead of replaying 65534 windows.
    force dut.frameCount_q = 16'hFFFE;
    #1;
    release dut.frameCount_q;
    cyc();
    vblank = 1'b1;
    cyc();
    checks++; if (frame_count !== 16'hFFFF) begin errors++; $display("[TB] FAIL wrap_top: got %h expected ffff", frame_count); end
    vblank = 1'b0;
    cyc();
    cyc();
    vblank = 1'b1;
    cyc();
    checks++; if (frame_count !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_zero: got %h expected 0000", frame_count); end
    vblank = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_once_per_window();
    test_timeout();
    test_overrun();
    test_reset_mid_grant();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
